relu3_sequencer: RTL
====================

RELU3_SEQUENCER -- requirements
Module: relu3_sequencer

Interface
REQ-001 SHALL have parameter: N, 64, number of elements per pass (1..65535).
REQ-002 SHALL have parameter: DATA_W, 32, signed element width.
REQ-003 SHALL have parameter: ADDR_W, 16, address width.
REQ-004 SHALL have parameter: CLIP_MAX, 32'sh0000_FFFF, positive clamp ceiling (used only under RELU3_CLIP_EN).
REQ-005 SHALL have port: clk  input  1  single clock, all logic on rising edge; reset is synchronous and active-low.
REQ-006 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port: start  input  1  request one pass, sampled only in IDLE.
REQ-008 SHALL have port: src_addr  output  ADDR_W  read address to source memory (combinational-read memory).
REQ-009 SHALL have port: src_data  input  DATA_W signed  source word for src_addr, same cycle.
REQ-010 SHALL have port: dst_addr  output  ADDR_W  write address to relu3 memory.
REQ-011 SHALL have port: dst_data  output  DATA_W signed  write data to relu3 memory.
REQ-012 SHALL have port: dst_we  output  1  write enable to relu3 memory.
REQ-013 SHALL have port: busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port: count  output  ADDR_W  number of writes issued in current/last pass.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-017 SHALL transition IDLE->RUN on edge with start=1, read index idx cleared to 0, count cleared to 0.
REQ-018 SHALL drive src_addr = idx combinationally in RUN; 0 in other states.
REQ-019 SHALL, on each RUN edge, register dst_addr<=idx, dst_data<=relu(src_data), dst_we<=1, count<=count+1, idx<=idx+1.
REQ-020 SHALL transition RUN->DRAIN on the edge that captures idx=N-1; DRAIN->DONE next edge (dst_we<=0); DONE->IDLE next edge.
REQ-021 SHALL give latency: start edge E0; dst_we high for exactly N cycles after E1..EN; done high for one cycle after E(N+1); busy low again after E(N+2).
REQ-022 SHALL compute relu(x) = x if x>0, else 0; 0 and most-negative value (0x8000_0000) map to 0; no width change.
REQ-023 SHALL ignore start while busy=1; no restart, no queuing.
REQ-024 SHALL keep dst_addr, dst_data, count stable in IDLE/DONE (last values held); dst_we=0 outside the cycles of REQ-021.
REQ-025 SHALL never issue dst_addr >= N.

Reset
REQ-026 SHALL, on rst_n=0 at a clock edge, set state=IDLE, idx=0, count=0, dst_addr=0, dst_data=0, dst_we=0, done=0, busy=0.
REQ-027 SHALL, when reset is applied mid-pass, abandon the pass with no further writes after that edge and no done pulse.
REQ-028 SHALL let reset take priority over start on the same edge.

Configuration
REQ-029 SHALL, with RELU3_CLIP_EN defined, clamp output: relu(x) = CLIP_MAX if x > CLIP_MAX.
REQ-030 SHALL, with RELU3_CLIP_EN undefined, apply pure ReLU (REQ-022); CLIP_MAX unused.

Verification
REQ-031 SHALL pass: src_data = addr-32 for addr 0..63, start pulse -> writes addr 0..32 = 0, addr 33..63 = 1..31; done once; count=64.
REQ-032 SHALL pass: src_data = 0x8000_0000, 0x0000_0000, 0x7FFF_FFFF at addr 0..2 -> written 0, 0, 0x7FFF_FFFF (0x0000_FFFF with RELU3_CLIP_EN).
REQ-033 SHALL pass: start at E0 -> dst_we high exactly 64 cycles (after E1..E64), done after E65, busy low after E66.
REQ-034 SHALL pass: start re-pulsed at E10 and E40 -> no effect, still 64 writes, one done.
REQ-035 SHALL pass: rst_n=0 at E20 -> dst_we=0, busy=0, count=0 after E20; no done; new start then completes normally.
REQ-036 SHALL pass: start held high continuously -> back-to-back passes separated by DRAIN+DONE, each 64 writes and one done.

Source files
------------

// File: rtl/relu3_sequencer.sv
// Streams N signed words from a source memory through ReLU into a destination memory.
// Optional output ceiling enabled by defining RELU3_CLIP_EN (clamps results to CLIP_MAX).
module relu3_sequencer #(
  parameter int unsigned                N        = 64,
  parameter int unsigned                DATA_W   = 32,
  parameter int unsigned                ADDR_W   = 16,
  parameter logic signed [DATA_W-1:0]   CLIP_MAX = 32'sh0000_FFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [ADDR_W-1:0]         src_addr,
  input  logic signed [DATA_W-1:0]  src_data,
  output logic [ADDR_W-1:0]         dst_addr,
  output logic signed [DATA_W-1:0]  dst_data,
  output logic                      dst_we,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [ADDR_W-1:0]          r_idx;
  logic [ADDR_W-1:0]          r_count;
  logic [ADDR_W-1:0]          r_dst_addr;
  logic signed [DATA_W-1:0]   r_dst_data;
  logic                       r_dst_we;
  logic                       r_busy;
  logic                       r_done;

  // Positive values pass through; zero and all negatives (including the most negative) become zero.
  function automatic logic signed [DATA_W-1:0] relu3(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] y;
    if ((x[DATA_W-1] == 1'b0) && (x != {DATA_W{1'b0}})) begin
      y = x;
    end else begin
      y = {DATA_W{1'b0}};
    end
`ifdef RELU3_CLIP_EN
    if (y > CLIP_MAX) begin
      y = CLIP_MAX;
    end else begin
      y = y;
    end
`endif
    return y;
  endfunction

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Read address follows the index only while reading.
  always_comb begin
    if (r_state == S_RUN) begin
      src_addr = r_idx;
    end else begin
      src_addr = {ADDR_W{1'b0}};
    end
  end

  // State, index and registered write port; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= {ADDR_W{1'b0}};
      r_count    <= {ADDR_W{1'b0}};
      r_dst_addr <= {ADDR_W{1'b0}};
      r_dst_data <= {DATA_W{1'b0}};
      r_dst_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (r_state == S_DRAIN);
      case (r_state)
        S_IDLE: begin
          r_dst_we <= 1'b0;
          if (start) begin
            r_idx   <= {ADDR_W{1'b0}};
            r_count <= {ADDR_W{1'b0}};
          end else begin
            r_idx   <= r_idx;
            r_count <= r_count;
          end
        end
        S_RUN: begin
          r_dst_addr <= r_idx;
          r_dst_data <= relu3(src_data);
          r_dst_we   <= 1'b1;
          r_count    <= r_count + ONE;
          r_idx      <= r_idx + ONE;
        end
        S_DRAIN: r_dst_we <= 1'b0;
        S_DONE:  r_dst_we <= 1'b0;
        default: r_dst_we <= 1'b0;
      endcase
    end
  end

  assign dst_addr = r_dst_addr;
  assign dst_data = r_dst_data;
  assign dst_we   = r_dst_we;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;

endmodule
